// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command stream into APB3 transfers
// with a bounded ACCESS phase and a one-cycle response pulse.
//
// Ports:
//   PCLK, PRESETn                     - clock, async active-low reset
//   req_valid/req_ready               - command handshake
//   req_write, req_addr, req_wdata    - command payload
//   rsp_valid, rsp_rdata, rsp_err     - completion pulse, read data, timeout flag
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY            - APB master side
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    // Counter value at which a stalled ACCESS cycle becomes the last one.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  tmo;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_ready   = 1'b0;
        tmo         = !PREADY && (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY || tmo) begin
                    req_ready   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !PREADY;
                    if (PREADY && !pwrite_q) begin
                        rsp_rdata_d = PRDATA;
                    end
                    // A command offered now chains straight into SETUP.
                    if (req_valid) begin
                        pwrite_d = req_write;
                        paddr_d  = req_addr;
                        pwdata_d = req_wdata;
                        state_d  = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data bus width; ADDR_WIDTH, default 32, address width; TIMEOUT, default 16, maximum ACCESS cycles (legal range 2..255).
REQ-002 PCLK  in  1  clock; all state changes on rising edge.
REQ-003 PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  command request present.
REQ-005 req_ready  out  1  bridge accepts command this cycle.
REQ-006 req_write  in  1  1=write, 0=read.
REQ-007 req_addr  in  ADDR_WIDTH  transfer address.
REQ-008 req_wdata  in  DATA_WIDTH  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
REQ-011 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-012 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-013 PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH  APB address and write data.
REQ-014 PRDATA  in  DATA_WIDTH; PREADY  in  1  APB read data and slave ready.

Function
REQ-015 FSM SHALL have states IDLE, SETUP, ACCESS; all APB outputs SHALL be registered or decoded from state only.
REQ-016 IDLE: PSEL=0, PENABLE=0; SETUP: PSEL=1, PENABLE=0; ACCESS: PSEL=1, PENABLE=1.
REQ-017 req_ready SHALL be 1 in IDLE, 1 in ACCESS in the cycle the transfer completes, and 0 otherwise.
REQ-018 Acceptance = req_valid && req_ready at a rising edge; the edge SHALL latch req_write/req_addr/req_wdata into PWRITE/PADDR/PWDATA and enter SETUP.
REQ-019 SETUP SHALL last exactly one cycle, then enter ACCESS unconditionally.
REQ-020 PADDR, PWRITE, PWDATA SHALL remain stable from SETUP through the final ACCESS cycle, and SHALL hold their last values while IDLE.
REQ-021 A wait counter SHALL clear on ACCESS entry and increment every ACCESS cycle with PREADY=0.
REQ-022 Completion SHALL occur in an ACCESS cycle where PREADY=1 (normal) or where PREADY=0 and the counter equals TIMEOUT-1 (timeout); ACCESS SHALL therefore never exceed TIMEOUT cycles.
REQ-023 On the completing edge: rsp_valid SHALL be set for exactly one cycle; rsp_err = 1 only for timeout; rsp_rdata = PRDATA sampled that edge for normal reads, else 0.
REQ-024 On completion with acceptance in the same cycle, the next state SHALL be SETUP (no IDLE gap, PSEL held 1); otherwise the next state SHALL be IDLE.
REQ-025 rsp_valid for transfer N and SETUP of transfer N+1 SHALL coincide in back-to-back operation.
REQ-026 PRDATA SHALL be ignored outside completing ACCESS cycles and for writes.
REQ-027 State encodings outside the defined three SHALL return to IDLE.

Reset
REQ-028 PRESETn low SHALL immediately force state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0; wait counter = 0.
REQ-029 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse; req_ready SHALL be 1 in the first cycle after release.

Verification
REQ-030 Reset: assert PRESETn low mid-sim -> all outputs 0 within same cycle, req_ready=1 after release.
REQ-031 Write 0xDEADBEEF to 0x10, PREADY tied 1 -> SETUP cycle 1, ACCESS cycle 2 with PWRITE=1/PADDR=0x10, rsp_valid cycle 3, rsp_err=0.
REQ-032 Read 0x20, PREADY low 3 ACCESS cycles then high with PRDATA=0xA5A5A5A5 -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0xA5A5A5A5, rsp_err=0.
REQ-033 Two back-to-back writes (req_valid held 1), PREADY=1 -> PSEL continuously 1 for 4 cycles, PENABLE pattern 0,1,0,1, two rsp_valid pulses.
REQ-034 Read with PREADY held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, rsp_valid=1 with rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-035 PRESETn pulsed low during third ACCESS wait cycle -> PSEL/PENABLE drop immediately, no rsp_valid, next request completes normally.
